// File: rtl/ram_read_sequencer_pkg.sv
// Shared types and RAM geometry for the block-read sequencer and its FIFO.
// No logic: state encoding plus default widths matching the ram block.
package ram_read_sequencer_pkg;

    localparam int RAM_ADDR_WIDTH = 16;
    localparam int RAM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_read_fifo.sv
// Output buffer: DEPTH-entry synchronous FIFO, head visible the cycle after push (no bypass).
// Pop is ignored when empty; the caller must never push into a full FIFO.
module ram_read_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop      = i_pop & (r_count != '0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);

    // Storage is cleared too so the head reads as zero straight out of reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_read_sequencer.sv
// Streams WordCount RAM words from StartAddress; first OutValid two cycles after Start, 1 word/cycle.
// Reads are only issued when the buffer is guaranteed room, so OutReady=0 simply stalls issue.
module ram_read_sequencer
    import ram_read_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] StartAddress,
    input  logic [ADDR_WIDTH-1:0] WordCount,
    output logic                  Busy,
    output logic                  Done,
    output logic                  RamEnable,
    output logic                  RamReadWrite,
    output logic [ADDR_WIDTH-1:0] RamAddress,
    input  logic [DATA_WIDTH-1:0] RamDataOut,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  OutLast
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_ram_en;
    logic                  r_issue_last;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [ADDR_WIDTH-1:0] r_remaining;

    logic                  w_issue_first;
    logic                  w_issue;
    logic                  w_done_set;
    logic                  w_pop;
    logic                  w_fifo_empty;
    logic [CW-1:0]         w_fifo_count;
    logic [CW-1:0]         w_occ_next;
    logic [DATA_WIDTH:0]   w_head;

    ram_read_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_push     (r_ram_en),
        .i_push_dat ({r_issue_last, RamDataOut}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_fifo_count),
        .o_empty    (w_fifo_empty)
    );

    assign OutValid     = !w_fifo_empty;
    assign OutData      = w_head[DATA_WIDTH-1:0];
    assign OutLast      = OutValid & w_head[DATA_WIDTH];
    assign w_pop        = OutValid & OutReady;
    assign Busy         = (r_state != S_IDLE);
    assign Done         = r_done;
    assign RamEnable    = r_ram_en;
    assign RamAddress   = r_ram_addr;
    assign RamReadWrite = 1'b1;

    // Occupancy once this cycle's push and pop have landed; next-cycle pops are not credited.
    assign w_occ_next = w_fifo_count + CW'(r_ram_en) - CW'(w_pop);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_issue_first = 1'b0;
        w_issue       = 1'b0;
        w_done_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (WordCount != '0) begin
                        w_next_state  = S_READ;
                        w_issue_first = 1'b1;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (r_remaining == '0) begin
                    w_next_state = S_DRAIN;
                end else if (w_occ_next <= CW'(FIFO_DEPTH - 1)) begin
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_pop && w_head[DATA_WIDTH]) begin
                    w_next_state = S_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // r_remaining counts reads still to issue beyond the one currently on the RAM port.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ram_en     <= 1'b0;
            r_issue_last <= 1'b0;
            r_done       <= 1'b0;
            r_ram_addr   <= '0;
            r_remaining  <= '0;
        end else begin
            r_ram_en <= w_issue_first | w_issue;
            r_done   <= w_done_set;
            if (w_issue_first) begin
                r_ram_addr   <= StartAddress;
                r_remaining  <= WordCount - ADDR_WIDTH'(1);
                r_issue_last <= (WordCount == ADDR_WIDTH'(1));
            end else if (w_issue) begin
                r_ram_addr   <= r_ram_addr + ADDR_WIDTH'(1);
                r_remaining  <= r_remaining - ADDR_WIDTH'(1);
                r_issue_last <= (r_remaining == ADDR_WIDTH'(1));
            end
        end
    end

endmodule

// File: tb/tb_ram_read_sequencer.sv
// Directed plus randomized block reads against a queue-based model of the expected word stream.
module tb_ram_read_sequencer;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [AW-1:0] StartAddress = '0;
    logic [AW-1:0] WordCount = '0;
    logic          OutReady = 1'b0;
    logic          Busy, Done, RamEnable, RamReadWrite, OutValid, OutLast;
    logic [AW-1:0] RamAddress;
    logic [DW-1:0] RamDataOut, OutData;

    logic [DW-1:0] mem [0:65535];

    assign RamDataOut = mem[RamAddress];

    always #5 Clock = ~Clock;

    ram_read_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .StartAddress (StartAddress),
        .WordCount    (WordCount),
        .Busy         (Busy),
        .Done         (Done),
        .RamEnable    (RamEnable),
        .RamReadWrite (RamReadWrite),
        .RamAddress   (RamAddress),
        .RamDataOut   (RamDataOut),
        .OutData      (OutData),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutLast      (OutLast)
    );

    int            n_assert = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            buffered = 0;
    int            accepted = 0;
    int            done_cnt = 0;
    logic          exp_busy = 1'b0;
    logic          exp_done = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [DW:0]   exp_q [$];
    logic [AW-1:0] addr_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  Busy, 0);
        check({tag, "_done"},  Done, 0);
        check({tag, "_en"},    RamEnable, 0);
        check({tag, "_addr"},  RamAddress, 0);
        check({tag, "_valid"}, OutValid, 0);
        check({tag, "_data"},  OutData, 0);
        check({tag, "_last"},  OutLast, 0);
        check({tag, "_rw"},    RamReadWrite, 1);
    endtask

    // One clock cycle: check this cycle's outputs against the model, then advance.
    task automatic run_cycle(input logic rdy);
        logic        pop;
        logic        nb;
        logic        nd;
        logic [DW:0] e;
        OutReady = rdy;
        check("rw_const", RamReadWrite, 1);
        check("busy", Busy, exp_busy);
        check("done", Done, exp_done);
        check("valid_vs_buffered", OutValid, buffered != 0);
        check("buffer_bound", buffered <= DEPTH, 1);
        if (Done) done_cnt++;
        if (prev_stall) begin
            check("stall_data", OutData, prev_data);
            check("stall_last", OutLast, prev_last);
        end
        nb = exp_busy;
        nd = 1'b0;
        if (Start && !exp_busy) begin
            if (WordCount == 0) begin
                nd = 1'b1;
            end else begin
                nb = 1'b1;
                for (int i = 0; i < int'(WordCount); i++) begin
                    logic [AW-1:0] a;
                    a = StartAddress + AW'(i);
                    exp_q.push_back({(i == int'(WordCount) - 1), mem[a]});
                    addr_q.push_back(a);
                end
            end
        end
        pop = OutValid & rdy;
        if (pop) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", OutValid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", OutData, e[DW-1:0]);
                check("out_last", OutLast, e[DW]);
                accepted++;
                if (e[DW]) begin
                    nb = 1'b0;
                    nd = 1'b1;
                end
            end
        end
        if (RamEnable) begin
            if (addr_q.size() == 0) check("spurious_read", RamEnable, 0);
            else check("ram_addr", RamAddress, addr_q.pop_front());
        end
        buffered   = buffered + (RamEnable ? 1 : 0) - (pop ? 1 : 0);
        prev_stall = OutValid & !rdy;
        prev_data  = OutData;
        prev_last  = OutLast;
        exp_busy   = nb;
        exp_done   = nd;
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    function automatic logic rdy_for(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return cyc[0];
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic start_xfer(input logic [AW-1:0] addr, input logic [AW-1:0] cnt, input logic rdy);
        Start        = 1'b1;
        StartAddress = addr;
        WordCount    = cnt;
        run_cycle(rdy);
        Start        = 1'b0;
    endtask

    task automatic drain(input int mode);
        int n;
        n = 0;
        while ((exp_busy || exp_done) && n < 400) begin
            run_cycle(rdy_for(mode));
            n++;
        end
        check("drain_timeout", exp_busy, 0);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        addr_q.delete();
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        buffered   = 0;
        prev_stall = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int d0;
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[0] = 32'hAAAAAAAA; mem[1] = 32'h00AABBCC; mem[2] = 32'h00BB2351;
        mem[3] = 32'h00CCFFFF; mem[4] = 32'h00DDABCD; mem[5] = 32'h00000000;
        mem[6] = 32'hFFFFEFFF; mem[7] = 32'hEEEEEEEE;

        // Reset state
        #2;
        check_reset_outputs("reset");
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        run_cycle(1'b1);

        // 1: full 8-word stream with OutReady held high
        start_xfer(16'h0000, 16'd8, 1'b1);
        check("t1_en_after_start", RamEnable, 1);
        check("t1_valid_latency", OutValid, 0);
        run_cycle(1'b1);
        for (int i = 0; i < 8; i++) begin
            check("t1_back_to_back", OutValid, 1);
            run_cycle(1'b1);
        end
        check("t1_done_pulse", Done, 1);
        check("t1_busy_clear", Busy, 0);
        run_cycle(1'b1);

        // 2: toggling OutReady
        base = accepted;
        start_xfer(16'h0002, 16'd3, 1'b0);
        drain(1);
        check("t2_word_count", accepted - base, 3);

        // 3: zero-length request
        start_xfer(16'h0010, 16'd0, 1'b1);
        check("t3_done", Done, 1);
        check("t3_no_read", RamEnable, 0);
        check("t3_not_busy", Busy, 0);
        run_cycle(1'b1);
        check("t3_no_read_after", RamEnable, 0);

        // 4: address wrap
        mem[16'hFFFE] = 32'h11111111;
        mem[16'hFFFF] = 32'h22222222;
        base = accepted;
        start_xfer(16'hFFFE, 16'd3, 1'b1);
        drain(0);
        check("t4_word_count", accepted - base, 3);
        check("t4_addr_wrapped", RamAddress, 16'h0000);

        // 5: Start while busy is ignored
        base = accepted;
        d0 = done_cnt;
        start_xfer(16'h0000, 16'd8, 1'b0);
        for (int i = 0; i < 5; i++) run_cycle(1'b0);
        start_xfer(16'h0004, 16'd4, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(1'b0);
        drain(0);
        check("t5_word_count", accepted - base, 8);
        check("t5_single_done", done_cnt - d0, 1);

        // 6: reset after three accepted words
        base = accepted;
        d0 = done_cnt;
        start_xfer(16'h0000, 16'd8, 1'b1);
        n = 0;
        while (accepted - base < 3 && n < 20) begin
            run_cycle(1'b1);
            n++;
        end
        check("t6_three_accepted", accepted - base, 3);
        Reset = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        model_clear();
        @(posedge Clock);
        #1;
        check_reset_outputs("t6_held");
        Reset = 1'b0;
        run_cycle(1'b1);
        check("t6_no_done", done_cnt - d0, 0);
        base = accepted;
        start_xfer(16'h0005, 16'd1, 1'b1);
        drain(0);
        check("t6_one_word", accepted - base, 1);

        // Randomized transfers
        for (int k = 0; k < 10; k++) begin
            logic [AW-1:0] ra;
            logic [AW-1:0] rc;
            int            mode;
            ra   = AW'($urandom);
            rc   = AW'($urandom_range(0, 10));
            mode = $urandom_range(0, 2);
            base = accepted;
            start_xfer(ra, rc, rdy_for(mode));
            drain(mode);
            check("rand_word_count", accepted - base, int'(rc));
        end
        run_cycle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
